// File: rtl/arm_cond_pkg.sv
// Shared condition/flag definitions for the ARM datapath (decoder and cond_logic).
// Flag order within flags_t: N=3, Z=2, C=1, V=0.
package arm_cond_pkg;

  localparam int unsigned FLAG_W = 4;
  localparam int unsigned COND_W = 4;

  typedef logic [FLAG_W-1:0] flags_t;

  localparam int unsigned FLAG_N = 3;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 0;

  localparam logic [COND_W-1:0] COND_EQ = 4'b0000;
  localparam logic [COND_W-1:0] COND_NE = 4'b0001;
  localparam logic [COND_W-1:0] COND_CS = 4'b0010;
  localparam logic [COND_W-1:0] COND_CC = 4'b0011;
  localparam logic [COND_W-1:0] COND_MI = 4'b0100;
  localparam logic [COND_W-1:0] COND_PL = 4'b0101;
  localparam logic [COND_W-1:0] COND_VS = 4'b0110;
  localparam logic [COND_W-1:0] COND_VC = 4'b0111;
  localparam logic [COND_W-1:0] COND_HI = 4'b1000;
  localparam logic [COND_W-1:0] COND_LS = 4'b1001;
  localparam logic [COND_W-1:0] COND_GE = 4'b1010;
  localparam logic [COND_W-1:0] COND_LT = 4'b1011;
  localparam logic [COND_W-1:0] COND_GT = 4'b1100;
  localparam logic [COND_W-1:0] COND_LE = 4'b1101;
  localparam logic [COND_W-1:0] COND_AL = 4'b1110;
  localparam logic [COND_W-1:0] COND_NV = 4'b1111;

endpackage

// File: rtl/cond_check.sv
// Combinational condition evaluator: maps the instruction condition field and
// the stored NZCV flags to a pass/fail bit.
//   cond    in  4  instruction bits [31:28]
//   flags   in  4  stored NZCV
//   cond_ex out 1  condition passed (1111 always fails)
module cond_check
  import arm_cond_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       cond_ex
);

  logic n, z, c, v;
  logic ge;

  assign n  = flags[2'(FLAG_N)];
  assign z  = flags[2'(FLAG_Z)];
  assign c  = flags[2'(FLAG_C)];
  assign v  = flags[2'(FLAG_V)];
  assign ge = (n == v);

  // One arm per condition code
  always_comb begin
    cond_ex = 1'b0;
    unique case (cond)
      COND_EQ: cond_ex = z;
      COND_NE: cond_ex = !z;
      COND_CS: cond_ex = c;
      COND_CC: cond_ex = !c;
      COND_MI: cond_ex = n;
      COND_PL: cond_ex = !n;
      COND_VS: cond_ex = v;
      COND_VC: cond_ex = !v;
      COND_HI: cond_ex = c && !z;
      COND_LS: cond_ex = !c || z;
      COND_GE: cond_ex = ge;
      COND_LT: cond_ex = !ge;
      COND_GT: cond_ex = !z && ge;
      COND_LE: cond_ex = z || !ge;
      COND_AL: cond_ex = 1'b1;
      COND_NV: cond_ex = 1'b0;
      default: cond_ex = 1'b0;
    endcase
  end

endmodule

// File: rtl/cond_logic.sv
// Condition and flag stage: holds NZCV, evaluates the current instruction's
// condition and gates the decoder's write/branch enables.
//   clk, reset   clock and synchronous active-high reset
//   Cond         instruction condition field
//   ALUFlagsIn   NZCV from the ALU for this instruction
//   FlagW        [1] writes N,Z  [0] writes C,V
//   PCS/RegW/MemW/NoWrite  decoder requests
//   PCSrc/RegWrite/MemWrite gated enables (combinational)
//   CondEx       condition passed (combinational)
//   ZFlag/Flags  stored Z / stored NZCV
module cond_logic
  import arm_cond_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] Cond,
  input  logic [3:0] ALUFlagsIn,
  input  logic [1:0] FlagW,
  input  logic       PCS,
  input  logic [1:0] RegW,
  input  logic       MemW,
  input  logic       NoWrite,
  output logic       PCSrc,
  output logic [1:0] RegWrite,
  output logic       MemWrite,
  output logic       CondEx,
  output logic       ZFlag,
  output logic [3:0] Flags
);

  flags_t flags_q;
  logic   cond_pass;

  cond_check u_cond_check (
    .cond    (Cond),
    .flags   (flags_q),
    .cond_ex (cond_pass)
  );

  // Gated enables; all forced low while reset is held
  always_comb begin
    CondEx   = 1'b0;
    PCSrc    = 1'b0;
    MemWrite = 1'b0;
    RegWrite = 2'b00;
    if (!reset) begin
      CondEx   = cond_pass;
      PCSrc    = PCS && cond_pass;
      MemWrite = MemW && cond_pass;
      RegWrite = RegW & {2{cond_pass && !NoWrite}};
    end
  end

  // Flag register: groups written independently, only when the condition passes
  always_ff @(posedge clk) begin
    if (reset) begin
      flags_q <= '0;
    end else begin
      if (FlagW[1] && cond_pass) begin
        flags_q[2'(FLAG_N)] <= ALUFlagsIn[2'(FLAG_N)];
        flags_q[2'(FLAG_Z)] <= ALUFlagsIn[2'(FLAG_Z)];
      end
      if (FlagW[0] && cond_pass) begin
        flags_q[2'(FLAG_C)] <= ALUFlagsIn[2'(FLAG_C)];
        flags_q[2'(FLAG_V)] <= ALUFlagsIn[2'(FLAG_V)];
      end
    end
  end

  assign ZFlag = flags_q[2'(FLAG_Z)];
  assign Flags = flags_q;

endmodule

// File: tb/tb_cond_logic.sv
// Scoreboard bench for cond_logic: a driver issues one instruction per cycle and
// pushes the reference model's expected response; a monitor pops and compares.
module tb_cond_logic;

  logic       clk;
  logic       reset;
  logic [3:0] Cond;
  logic [3:0] ALUFlagsIn;
  logic [1:0] FlagW;
  logic       PCS;
  logic [1:0] RegW;
  logic       MemW;
  logic       NoWrite;
  logic       PCSrc;
  logic [1:0] RegWrite;
  logic       MemWrite;
  logic       CondEx;
  logic       ZFlag;
  logic [3:0] Flags;

  cond_logic dut (
    .clk        (clk),
    .reset      (reset),
    .Cond       (Cond),
    .ALUFlagsIn (ALUFlagsIn),
    .FlagW      (FlagW),
    .PCS        (PCS),
    .RegW       (RegW),
    .MemW       (MemW),
    .NoWrite    (NoWrite),
    .PCSrc      (PCSrc),
    .RegWrite   (RegWrite),
    .MemWrite   (MemWrite),
    .CondEx     (CondEx),
    .ZFlag      (ZFlag),
    .Flags      (Flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      tag;
    logic       condex;
    logic       pcsrc;
    logic [1:0] regw;
    logic       memw;
    logic [3:0] flags;
    logic       fchk;
  } exp_t;

  exp_t expq[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  // Reference model state: architectural NZCV
  logic [3:0] mflags;
  logic       mknown = 1'b0;

  // ARM rule: cond[3:1] picks a base test, cond[0] inverts it; 1110 always, 1111 never
  function automatic logic model_cond(input logic [3:0] c, input logic [3:0] f);
    int  n, z, cf, v;
    logic base;
    n = int'(f[3]); z = int'(f[2]); cf = int'(f[1]); v = int'(f[0]);
    if (c == 4'd14) return 1'b1;
    if (c == 4'd15) return 1'b0;
    case (int'(c) / 2)
      0: base = (z == 1);
      1: base = (cf == 1);
      2: base = (n == 1);
      3: base = (v == 1);
      4: base = (cf == 1) && (z == 0);
      5: base = (n == v);
      default: base = (z == 0) && (n == v);
    endcase
    return (int'(c) % 2 == 1) ? !base : base;
  endfunction

  task automatic step(input string tag, input logic rst, input logic [3:0] c,
                      input logic [3:0] af, input logic [1:0] fw, input logic p,
                      input logic [1:0] rw, input logic mw, input logic nw);
    exp_t e;
    logic pass;
    @(negedge clk);
    reset = rst; Cond = c; ALUFlagsIn = af; FlagW = fw;
    PCS = p; RegW = rw; MemW = mw; NoWrite = nw;
    pass     = !rst && mknown && model_cond(c, mflags);
    e.tag    = tag;
    e.condex = pass;
    e.pcsrc  = p && pass;
    e.regw   = (pass && !nw) ? rw : 2'b00;
    e.memw   = mw && pass;
    e.flags  = mflags;
    e.fchk   = mknown;
    expq.push_back(e);
    if (rst) begin
      mflags = 4'b0000;
      mknown = 1'b1;
    end else if (pass) begin
      if (fw[1]) mflags[3:2] = af[3:2];
      if (fw[0]) mflags[1:0] = af[1:0];
    end
  endtask

  task automatic chk(input string tag, input string what, input logic [3:0] got,
                     input logic [3:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s cyc=%0d %s got=%b want=%b", tag, cyc, what, got, want);
    end
  endtask

  // Monitor: every cycle the DUT presents a response; compare mid-cycle
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #3;
      cyc++;
      if (expq.size() > 0) begin
        e = expq.pop_front();
        chk(e.tag, "CondEx",   {3'b0, CondEx},   {3'b0, e.condex});
        chk(e.tag, "PCSrc",    {3'b0, PCSrc},    {3'b0, e.pcsrc});
        chk(e.tag, "RegWrite", {2'b0, RegWrite}, {2'b0, e.regw});
        chk(e.tag, "MemWrite", {3'b0, MemWrite}, {3'b0, e.memw});
        if (e.fchk) begin
          chk(e.tag, "Flags", Flags, e.flags);
          chk(e.tag, "ZFlag", {3'b0, ZFlag}, {3'b0, e.flags[2]});
        end
      end
    end
  end

  // Hard time limit so the run always ends
  initial begin
    #2_000_000;
    bad++;
    $display("FAIL timeout cyc=%0d got=running want=finished", cyc);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    reset = 1'b1; Cond = 4'b0; ALUFlagsIn = 4'b0; FlagW = 2'b0;
    PCS = 1'b0; RegW = 2'b0; MemW = 1'b0; NoWrite = 1'b0;

    // Reset with every request asserted
    step("rst_all", 1, 4'b1110, 4'b1111, 2'b11, 1, 2'b11, 1, 0);
    step("rst_all2", 1, 4'b1110, 4'b1111, 2'b11, 1, 2'b11, 1, 0);
    // After deassertion flags are 0000: EQ fails, NE passes
    step("post_eq", 0, 4'b0000, 4'b0000, 2'b00, 1, 2'b11, 1, 0);
    step("post_ne", 0, 4'b0001, 4'b0000, 2'b00, 1, 2'b11, 1, 0);

    // CMP then BEQ
    step("cmp", 0, 4'b1110, 4'b0110, 2'b11, 0, 2'b11, 0, 1);
    step("beq", 0, 4'b0000, 4'b0000, 2'b00, 1, 2'b00, 0, 0);

    // Condition fail must not write memory or flags
    step("rst_cf", 1, 4'b1110, 4'b0000, 2'b00, 0, 2'b00, 0, 0);
    step("cfail", 0, 4'b0000, 4'b1111, 2'b11, 0, 2'b00, 1, 0);
    step("cfail_hold", 0, 4'b1110, 4'b1010, 2'b00, 0, 2'b00, 0, 0);

    // Partial write: only N,Z group updated
    step("set_1111", 0, 4'b1110, 4'b1111, 2'b11, 0, 2'b00, 0, 0);
    step("part_nz", 0, 4'b1110, 4'b0000, 2'b10, 0, 2'b00, 0, 0);
    step("part_cv", 0, 4'b1110, 4'b1111, 2'b01, 0, 2'b00, 0, 0);
    step("part_chk", 0, 4'b1110, 4'b0000, 2'b00, 0, 2'b00, 0, 0);

    // Signed conditions
    step("set_1001", 0, 4'b1110, 4'b1001, 2'b11, 0, 2'b00, 0, 0);
    step("ge_1001", 0, 4'b1010, 4'b0000, 2'b00, 1, 2'b00, 0, 0);
    step("lt_1001", 0, 4'b1011, 4'b0000, 2'b00, 1, 2'b00, 0, 0);
    step("gt_1001", 0, 4'b1100, 4'b0000, 2'b00, 1, 2'b00, 0, 0);
    step("le_1001", 0, 4'b1101, 4'b0000, 2'b00, 1, 2'b00, 0, 0);
    step("set_1000", 0, 4'b1110, 4'b1000, 2'b11, 0, 2'b00, 0, 0);
    step("ge_1000", 0, 4'b1010, 4'b0000, 2'b00, 1, 2'b00, 0, 0);
    step("lt_1000", 0, 4'b1011, 4'b0000, 2'b00, 1, 2'b00, 0, 0);
    step("set_0100", 0, 4'b1110, 4'b0100, 2'b11, 0, 2'b00, 0, 0);
    step("gt_0100", 0, 4'b1100, 4'b0000, 2'b00, 1, 2'b00, 0, 0);
    step("le_0100", 0, 4'b1101, 4'b0000, 2'b00, 1, 2'b00, 0, 0);

    // Reset on the same edge as a flag write
    step("rst_fw", 1, 4'b1110, 4'b1111, 2'b11, 0, 2'b00, 0, 0);
    step("rst_fw_chk", 0, 4'b1110, 4'b0000, 2'b00, 0, 2'b00, 0, 0);

    // Full sweep: every condition against every flag value, flags held
    for (int f = 0; f < 16; f++) begin
      step("sweep_set", 0, 4'b1110, 4'(f), 2'b11, 0, 2'b00, 0, 0);
      for (int c = 0; c < 16; c++) begin
        step("sweep", 0, 4'(c), 4'($urandom), 2'b00, 1'($urandom),
             2'($urandom), 1'($urandom), 1'($urandom));
      end
    end

    // Random instruction stream with occasional reset
    for (int i = 0; i < 400; i++) begin
      step("rand", ($urandom_range(0, 24) == 0), 4'($urandom), 4'($urandom),
           2'($urandom), 1'($urandom), 2'($urandom), 1'($urandom), 1'($urandom));
    end

    // Drain: monitor should have consumed every entry
    repeat (3) @(negedge clk);
    #5;
    total++;
    if (expq.size() != 0) begin
      bad++;
      $display("FAIL drain queue got=%0d want=0", expq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cond_logic.md
# cond_logic

Condition and flag stage for the single-cycle ARM datapath. It holds the architectural NZCV flag register, evaluates the 4-bit condition field of the current instruction against the stored flags, and gates the decoder's write and branch enables so that only instructions whose condition passes have architectural effect. It sits between the control decoder and the register file, data memory and PC mux. It also drives the decoder's single-bit `ALUFlags` input, which is the stored Z flag.

## Interface
Parameters: none. Flag order is fixed by the shared package: N=bit 3, Z=bit 2, C=bit 1, V=bit 0.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `Cond`  in  4  instruction bits [31:28].
- `ALUFlagsIn`  in  4  NZCV produced by the ALU for the current instruction.
- `FlagW`  in  2  flag-write request from the decoder. Bit 1 updates N and Z. Bit 0 updates C and V.
- `PCS`  in  1  decoder branch request.
- `RegW`  in  2  decoder register-write request, same encoding as the decoder's `RegWrite`.
- `MemW`  in  1  decoder memory-write request.
- `NoWrite`  in  1  compare-class instruction; suppresses the register write.
- `PCSrc`  out  1  gated branch select to the PC mux.
- `RegWrite`  out  2  gated register-file write enables.
- `MemWrite`  out  1  gated data-memory write enable.
- `CondEx`  out  1  the condition passed for the current instruction.
- `ZFlag`  out  1  stored Z flag; drives the decoder's `ALUFlags`.
- `Flags`  out  4  stored NZCV, for debug and the bench.

## Operation
- State: one 4-bit register `flags_q`. No other state.
- `CondEx` is combinational from `Cond` and `flags_q`:
  - EQ 0000 → Z
  - NE 0001 → !Z
  - CS 0010 → C
  - CC 0011 → !C
  - MI 0100 → N
  - PL 0101 → !N
  - VS 0110 → V
  - VC 0111 → !V
  - HI 1000 → C & !Z
  - LS 1001 → !C | Z
  - GE 1010 → N==V
  - LT 1011 → N!=V
  - GT 1100 → !Z & (N==V)
  - LE 1101 → Z | (N!=V)
  - AL 1110 → 1
  - 1111 (unsupported) → 0
- Gating:
  - `PCSrc = PCS & CondEx`
  - `MemWrite = MemW & CondEx`
  - `RegWrite = RegW & {2{CondEx & !NoWrite}}`
- Flag update at the clock edge:
  - If `FlagW[1] & CondEx`: N and Z ← `ALUFlagsIn[3:2]`.
  - If `FlagW[0] & CondEx`: C and V ← `ALUFlagsIn[1:0]`.
  - Bits whose group is not written hold their value.
  - A failed-condition instruction never changes any flag.
- `ZFlag = flags_q[2]`, `Flags = flags_q`.
- While `reset` is high:
  - `CondEx`, `PCSrc`, `RegWrite` and `MemWrite` are forced to 0, regardless of inputs.
  - `flags_q` loads 0000 at the edge.

## Timing
- Reset values: `flags_q`=0000, `Flags`=0000, `ZFlag`=0. Gated outputs are 0 while `reset` is asserted.
- Gated outputs and `CondEx` have zero-cycle latency: they are combinational from the current inputs and the stored flags.
- Flag latency is one cycle. Flags written by instruction *k* are visible to the condition of instruction *k+1*. An instruction never sees its own flag result.
- If `reset` and a `FlagW` request occur in the same cycle, reset wins and the flags become 0000.
- Reset asserted mid-program clears the flags at the next edge. The first instruction after deassertion evaluates against 0000, so EQ fails and NE passes.
- `FlagW`=00 with any `ALUFlagsIn` leaves the flags unchanged. Unknowns on `ALUFlagsIn` must not propagate when `FlagW`=00.
- Back-to-back flag writes each update on their own edge. There is no coalescing.

## Structure
- Shared package `arm_cond_pkg` holds:
  - the condition-code constants (COND_EQ … COND_AL, COND_NV);
  - the flag-index constants (FLAG_N, FLAG_Z, FLAG_C, FLAG_V);
  - a 4-bit typedef for `flags_t`.
  The decoder imports the same package.
- One combinational sub-module, `cond_check`, maps `Cond` and `flags_t` to `CondEx`. `cond_logic` holds the register and the gating.

## Test plan
- **Reset:** assert `reset` with `PCS`=1, `RegW`=11, `MemW`=1, `FlagW`=11, `ALUFlagsIn`=1111. Required: all gated outputs are 0, and after the edge `Flags`=0000.
- **CMP then BEQ:** apply `Cond`=1110, `FlagW`=11, `ALUFlagsIn`=0110, `NoWrite`=1, `RegW`=11. Required: `RegWrite`=00, and `Flags`=0110 on the next cycle. Then apply `Cond`=0000 with `PCS`=1. Required: `PCSrc`=1, `ZFlag`=1.
- **Condition fail:** with `Flags`=0000, apply `Cond`=0000, `MemW`=1, `FlagW`=11, `ALUFlagsIn`=1111. Required: `MemWrite`=0 and `Flags` stays 0000.
- **Partial write:** with `Flags`=1111, apply `FlagW`=10, `ALUFlagsIn`=0000, `Cond`=1110. Required: `Flags`=0011.
- **Signed conditions:**
  - `Flags`=1001 (N=V=1): GE passes, LT fails, GT passes, LE fails.
  - `Flags`=1000: GE fails, LT passes.
  - `Flags`=0100: GT fails, LE passes.
- **Remaining codes and reset mid-run:**
  - Sweep all 16 `Cond` codes for each of the 16 flag values against a reference model. Required: `Cond`=1111 always gives 0.
  - Assert `reset` on the same edge as a `FlagW`=11 write. Required: `Flags`=0000.
